// File: rtl/reg_file_8x8.sv
// Eight-entry register file, one-hot write strobes, two registered read ports, R7 as SP.
// Optional REG_ZERO_EN build hardwires R0 to zero.
module reg_file_8x8 #(
  parameter int unsigned    WIDTH    = 8,
  parameter logic [WIDTH-1:0] SP_RESET = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       we,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       ra_sel,
  input  logic [2:0]       rb_sel,
  input  logic             sp_inc,
  input  logic             sp_dec,
  input  logic             err_clr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  output logic [WIDTH-1:0] sp,
  output logic             we_err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] regs [8];
  logic [WIDTH-1:0] nxt  [8];
  logic             we_any;
  logic             we_one;
  logic             we_bad;
  logic             sp_wr;

  assign we_any = |we;
  assign we_one = we_any && ((we & (we - 8'd1)) == 8'd0);
  assign we_bad = we_any && !we_one;
  assign sp_wr  = we_one && we[7];

  // Next-state of every register; also feeds the write-first read bypass.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      nxt[i] = regs[i];
      if (we_one && we[i])
        nxt[i] = wdata;
    end
    if (!sp_wr) begin
      unique case (1'b1)
        sp_inc && !sp_dec: nxt[7] = regs[7] + ONE;
        sp_dec && !sp_inc: nxt[7] = regs[7] - ONE;
        default:           nxt[7] = regs[7];
      endcase
    end
`ifdef REG_ZERO_EN
    nxt[0] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 7; i++)
        regs[i] <= '0;
      regs[7] <= SP_RESET;
      ra_data <= '0;
      rb_data <= '0;
      we_err  <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++)
        regs[i] <= nxt[i];
      ra_data <= nxt[ra_sel];
      rb_data <= nxt[rb_sel];
      if (we_bad)
        we_err <= 1'b1;
      else if (err_clr)
        we_err <= 1'b0;
    end
  end

  assign sp = regs[7];

endmodule
